vram_writer: RTL and testbench
==============================

// Module: vram_writer
// PURPOSE
//  Write-side engine for port B of the dual-port screen RAM (the port the VGA path reads).
//  Performs bulk fills (clear-screen and pattern fill) and single-word host writes.
//  Owns ram address_b/data_b/wren_b and multiplexes the VGA read address when not writing.
//  Replaces the ad-hoc "wren_b = ~resetN, data_b = 0" clear with a full, deterministic clear.
// PARAMETERS
//  DATA_WIDTH          16     width of a RAM word
//  RAM_REGISTER_COUNT  1024   RAM depth; AW = $clog2(RAM_REGISTER_COUNT)
//  CLEAR_ON_RESET      1      1: auto-fill whole RAM with 0 after reset release
//  RAM_SCREEN_OFFSET   0      added to vga_addr before driving ram_addr_b
// PORTS
//  CLK_50        in   1           clock; single domain, same as RAM clock_b
//  resetN        in   1           synchronous, active-low reset
//  start         in   1           pulse: begin bulk fill
//  fill_base     in   AW          first address of fill, sampled with start
//  fill_count    in   AW+1        number of words to fill, sampled with start
//  fill_value    in   DATA_WIDTH  word written by fill, sampled with start
//  wr_valid      in   1           single-word write request
//  wr_ready      out  1           engine can accept a single write
//  wr_addr       in   AW          single-write address
//  wr_data       in   DATA_WIDTH  single-write data
//  vga_addr      in   DATA_WIDTH  VGA read word address
//  ram_addr_b    out  AW          to RAM address_b
//  ram_data_b    out  DATA_WIDTH  to RAM data_b
//  ram_wren_b    out  1           to RAM wren_b
//  busy          out  1           fill in progress
//  done          out  1           one-cycle pulse after last fill write
// BEHAVIOUR
//  - Reset (resetN=0 at edge): ram_wren_b=0, ram_data_b=0, busy=0, done=0, wr_ready=0;
//    state=RST. Reset mid-fill abandons the fill; no further writes from it.
//  - ram_wren_b, ram_data_b, busy, done are registered; ram_addr_b = write address when
//    ram_wren_b=1, else (vga_addr + RAM_SCREEN_OFFSET) truncated to AW (combinational mux).
//  - States: RST -> (CLEAR_ON_RESET ? FILL with base=0,count=RAM_REGISTER_COUNT,value=0 : IDLE);
//    IDLE -> FILL on start; IDLE -> SINGLE on wr_valid&&wr_ready; FILL -> IDLE after
//    last word; SINGLE -> IDLE after one cycle.
//  - Fill: start sampled at edge N -> first write (wren=1, addr=fill_base) in cycle N+1;
//    one word per cycle; addr increments, wraps modulo RAM_REGISTER_COUNT.
//    done=1 in the cycle after the last write, busy=1 exactly during write cycles.
//  - fill_count=0: no writes, busy stays 0, done pulses in cycle N+1.
//  - fill_count>RAM_REGISTER_COUNT clamped to RAM_REGISTER_COUNT.
//  - start while busy or in SINGLE: ignored. start and wr_valid same cycle in IDLE: start
//    wins, wr_ready=0 that cycle, single write stays pending (requester holds wr_valid).
//  - wr_ready = (state==IDLE) && !start. Accepted at edge N -> written in cycle N+1.
//  - During any write cycle the VGA sees the written word (read-during-write); acceptable.
// STRUCTURE
//  - vram_pkg: state enum (RST, IDLE, FILL, SINGLE), AW localparam helper function.
//  - Sub-module vram_addr_counter: loadable AW-bit wrap counter + remaining-word down count
//    with a last-word flag. Everything else flat in vram_writer.
// TESTING (RAM_REGISTER_COUNT=1024, CLEAR_ON_RESET=1 unless noted)
//  - Reset release -> 1024 consecutive writes addr 0..1023, data 0, busy high 1024 cycles,
//    done one pulse; RAM model all zero.
//  - start base=1020 count=8 value=16'hA5A5 -> writes 1020..1023,0..3, then done; others untouched.
//  - wr_valid addr=5 data=16'h1234 in IDLE -> wr_ready=1, one write next cycle, VGA addr
//    restored cycle after.
//  - start and wr_valid same cycle -> fill first, single write accepted after done, both land.
//  - resetN=0 after 10 fill writes -> next cycle wren=0, busy=0; clear restarts on release.
//  - start count=0 -> no wren, done pulse next cycle; start while busy -> no effect.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: state encoding and sizing helper shared by the VRAM port-B write engine
package vram_pkg;
  typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_FILL, ST_SINGLE} state_t;
  function automatic int addr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/vram_addr_counter.sv
// vram_addr_counter: loadable wrap-around address counter with remaining-word count and last flag
module vram_addr_counter import vram_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic [AW:0] remain;
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr <= '0;
      remain <= '0;
    end else if (load) begin
      addr <= base;
      remain <= count;
    end else if (step) begin
      addr <= addr == AW'(DEPTH - 1) ? '0 : addr + AW'(1);
      remain <= remain - (AW+1)'(1);
    end
  assign last = remain == (AW+1)'(1);
endmodule

// File: rtl/vram_writer.sv
// vram_writer: port-B write engine for the screen RAM; bulk fills, single host writes,
// and the VGA read address whenever no write is in flight
module vram_writer import vram_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int RAM_REGISTER_COUNT = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int RAM_SCREEN_OFFSET = 0,
  localparam int AW = addr_width(RAM_REGISTER_COUNT)
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [AW-1:0]         fill_base,
  input  logic [AW:0]           fill_count,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] vga_addr,
  output logic [AW-1:0]         ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_wren_b,
  output logic                  busy,
  output logic                  done
);
  localparam logic [AW:0] FULL = (AW+1)'(RAM_REGISTER_COUNT);
  state_t state, nxt;
  logic load, step, last, nxt_done;
  logic [AW-1:0] ld_base, addr;
  logic [AW:0] ld_count, fill_len;
  logic [DATA_WIDTH-1:0] nxt_data;
  vram_addr_counter #(.DEPTH(RAM_REGISTER_COUNT), .AW(AW)) u_cnt (
    .clk(CLK_50),
    .rst_n(resetN),
    .load(load),
    .step(step),
    .base(ld_base),
    .count(ld_count),
    .addr(addr),
    .last(last)
  );
  assign fill_len = fill_count > FULL ? FULL : fill_count;
  assign wr_ready = state == ST_IDLE && !start;
  assign ram_addr_b = ram_wren_b ? addr : AW'(vga_addr + DATA_WIDTH'(RAM_SCREEN_OFFSET));
  always_comb begin
    nxt = state;
    load = 1'b0;
    step = 1'b0;
    ld_base = '0;
    ld_count = '0;
    nxt_data = ram_data_b;
    nxt_done = 1'b0;
    case (state)
      ST_RST:
        if (CLEAR_ON_RESET) begin
          nxt = ST_FILL;
          load = 1'b1;
          ld_count = FULL;
          nxt_data = '0;
        end else nxt = ST_IDLE;
      ST_IDLE:
        if (start) begin
          // a zero-length fill completes immediately without touching the RAM
          nxt = fill_len == '0 ? ST_IDLE : ST_FILL;
          nxt_done = fill_len == '0;
          load = fill_len != '0;
          ld_base = fill_base;
          ld_count = fill_len;
          nxt_data = fill_value;
        end else if (wr_valid) begin
          nxt = ST_SINGLE;
          load = 1'b1;
          ld_base = wr_addr;
          ld_count = (AW+1)'(1);
          nxt_data = wr_data;
        end
      ST_FILL: begin
        nxt = last ? ST_IDLE : ST_FILL;
        nxt_done = last;
        step = !last;
      end
      ST_SINGLE: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK_50)
    if (!resetN) begin
      state <= ST_RST;
      ram_wren_b <= 1'b0;
      ram_data_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      ram_wren_b <= nxt == ST_FILL || nxt == ST_SINGLE;
      ram_data_b <= nxt_data;
      busy <= nxt == ST_FILL;
      done <= nxt_done;
    end
endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: randomized and directed bench for vram_writer against a queue-based write-schedule model
module tb_vram_writer;
  localparam int AW = 10, DW = 16, N = 1024;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; bit f; bit l;} rec_t;
  logic clk = 0, resetN = 0, start = 0, wr_valid = 0;
  logic wr_ready, ram_wren_b, busy, done;
  logic [AW-1:0] fill_base = '0, wr_addr = '0, ram_addr_b;
  logic [AW:0] fill_count = '0;
  logic [DW-1:0] fill_value = '0, wr_data = '0, vga_addr = '0, ram_data_b;
  int vecs = 0, errs = 0, wcnt = 0, dcnt = 0;
  rec_t q[$];
  bit in_rst = 1, m_wren = 0, m_busy = 0, m_done = 0, m_last = 0, started = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] mmem [N] = '{default: '0};
  logic [DW-1:0] dmem [N] = '{default: '0};

  always #10 clk = ~clk;

  vram_writer dut (
    .CLK_50(clk), .resetN(resetN), .start(start), .fill_base(fill_base),
    .fill_count(fill_count), .fill_value(fill_value), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .vga_addr(vga_addr),
    .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
    .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: every accepted command becomes a list of write cycles queued behind each other
  always @(posedge clk) begin
    bit nd, idle;
    int k;
    rec_t r;
    started = 1;
    if (!resetN) begin
      q.delete();
      in_rst = 1; m_wren = 0; m_busy = 0; m_done = 0; m_last = 0; m_data = '0;
    end else begin
      idle = !in_rst && !m_wren;
      nd = m_last;
      if (in_rst) begin
        in_rst = 0;
        for (int i = 0; i < N; i++) q.push_back('{AW'(i), '0, 1'b1, i == N - 1});
      end else if (idle && start) begin
        k = fill_count > N ? N : int'(fill_count);
        if (k == 0) nd = 1;
        for (int i = 0; i < k; i++) q.push_back('{AW'((fill_base + i) % N), fill_value, 1'b1, i == k - 1});
      end else if (idle && wr_valid) q.push_back('{wr_addr, wr_data, 1'b0, 1'b0});
      if (q.size() > 0) begin
        r = q.pop_front();
        m_wren = 1; m_addr = r.a; m_data = r.d; m_busy = r.f; m_last = r.l;
        mmem[r.a] = r.d;
      end else begin
        m_wren = 0; m_busy = 0; m_last = 0;
      end
      m_done = nd;
    end
  end

  always @(posedge clk) if (ram_wren_b === 1'b1) dmem[ram_addr_b] <= ram_data_b;

  always @(negedge clk) if (started) begin
    chk("wren", ram_wren_b, m_wren);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("wr_ready", wr_ready, !in_rst && !m_wren && !start);
    chk("addr_b", ram_addr_b, m_wren ? m_addr : vga_addr[AW-1:0]);
    if (m_wren || in_rst) chk("data_b", ram_data_b, m_data);
    wcnt += int'(ram_wren_b === 1'b1);
    dcnt += int'(done === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
    vga_addr = DW'($urandom);
  endtask

  task automatic wait_done(input string nm, input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      seen = done === 1'b1;
    end
    chk(nm, seen, 1);
    tick();
  endtask

  initial begin
    int w0, d0, bad;
    bit acc, quiet;
    repeat (3) tick();
    w0 = wcnt; d0 = dcnt;
    resetN = 1;
    wait_done("clear_done_seen", 1100);
    chk("clear_writes", wcnt - w0, 1024);
    chk("clear_done_pulses", dcnt - d0, 1);

    fill_base = 1020; fill_count = 8; fill_value = 16'hA5A5; start = 1;
    tick(); start = 0;
    wait_done("wrap_fill_done", 20);
    chk("wrap_1020", dmem[1020], 16'hA5A5);
    chk("wrap_3", dmem[3], 16'hA5A5);
    chk("wrap_4_untouched", dmem[4], 0);
    chk("wrap_1019_untouched", dmem[1019], 0);

    wr_addr = 5; wr_data = 16'h1234; wr_valid = 1;
    @(negedge clk); chk("single_ready", wr_ready, 1);
    tick(); wr_valid = 0;
    @(negedge clk); chk("single_wren", ram_wren_b, 1); chk("single_addr", ram_addr_b, 5);
    tick();
    @(negedge clk); chk("single_vga_restored", ram_addr_b, vga_addr[AW-1:0]); chk("single_mem", dmem[5], 16'h1234);
    tick();

    fill_base = 100; fill_count = 4; fill_value = 16'hBEEF; start = 1;
    wr_addr = 200; wr_data = 16'hCAFE; wr_valid = 1;
    @(negedge clk); chk("collide_ready_low", wr_ready, 0);
    tick(); start = 0; acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = wr_ready === 1'b1;
      tick();
    end
    chk("collide_single_accepted", acc, 1);
    wr_valid = 0;
    repeat (2) tick();
    chk("collide_fill", dmem[103], 16'hBEEF);
    chk("collide_single", dmem[200], 16'hCAFE);

    fill_base = 7; fill_count = 0; fill_value = 16'h5555; start = 1;
    tick(); start = 0;
    @(negedge clk); chk("zero_done", done, 1); chk("zero_no_write", ram_wren_b, 0);
    tick();

    fill_base = 400; fill_count = 20; fill_value = 16'h1111; start = 1;
    tick(); start = 0;
    repeat (5) tick();
    fill_base = 600; fill_count = 5; fill_value = 16'h2222; start = 1;
    tick(); start = 0;
    wait_done("busy_fill_done", 40);
    chk("busy_start_ignored", dmem[600], 0);
    chk("busy_fill_last", dmem[419], 16'h1111);

    fill_base = 300; fill_count = 50; fill_value = 16'h7777; start = 1;
    tick(); start = 0;
    repeat (9) tick();
    resetN = 0;
    tick();
    @(negedge clk); chk("rst_wren", ram_wren_b, 0); chk("rst_busy", busy, 0);
    chk("rst_partial_last", dmem[309], 16'h7777); chk("rst_partial_stop", dmem[310], 0);
    resetN = 1;
    wait_done("reclear_done", 1100);
    chk("reclear_309", dmem[309], 0);

    for (int c = 0; c < 2500; c++) begin
      start = $urandom_range(0, 7) == 0;
      wr_valid = $urandom_range(0, 2) == 0;
      fill_base = AW'($urandom); wr_addr = AW'($urandom);
      fill_value = DW'($urandom); wr_data = DW'($urandom);
      fill_count = $urandom_range(0, 9) == 0 ? (AW+1)'($urandom_range(1000, 2047)) : (AW+1)'($urandom_range(0, 40));
      tick();
    end
    start = 0; wr_valid = 0; quiet = 0;
    for (int i = 0; i < 1100 && !quiet; i++) begin
      @(negedge clk); quiet = ram_wren_b === 1'b0 && busy === 1'b0;
    end
    chk("drain", quiet, 1);
    tick(); tick();
    bad = 0;
    for (int i = 0; i < N; i++) bad += int'(dmem[i] !== mmem[i]);
    chk("ram_image", bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
